mp_add_ctrl: RTL and testbench

Multi-precision add/subtract sequencer built around one shared WIDTH-bit ripple adder (`adder`, ports A/B/Cin/Sum/Cout).
- Accepts two CHUNKS*WIDTH-bit operands over a valid/ready handshake.
- Feeds the operands through the adder one WIDTH-bit chunk per cycle, LSB chunk first, with a registered carry between chunks.
- Returns the full-width result over a second valid/ready handshake.
- Sits between a requesting datapath stage and the narrow adder, trading latency for area.

---
 rtl/mp_add_ctrl_pkg.sv | 20 ++
 rtl/adder.sv | 24 ++
 rtl/mp_add_ctrl.sv | 132 +++++++++++++
 tb/tb_mp_add_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encoding and the chunk-index width helper.
package mp_add_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned idx_w(input int unsigned chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/adder.sv
// Narrow WIDTH-bit ripple-carry adder shared by the multi-precision sequencer.
module adder #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  always_comb begin
    logic [WIDTH:0] carry;
    carry    = '0;
    Sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    Cout = carry[WIDTH];
  end

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract sequencer: streams CHUNKS*WIDTH-bit operands through one
// WIDTH-bit adder, LSB chunk first, with a registered inter-chunk carry.
module mp_add_ctrl
  import mp_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [WIDTH*CHUNKS-1:0] op_a,
  input  logic [WIDTH*CHUNKS-1:0] op_b,
  input  logic                    op_cin,
  input  logic                    op_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH*CHUNKS-1:0] sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int unsigned N    = WIDTH * CHUNKS;
  localparam int unsigned IdxW = idx_w(CHUNKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHUNKS - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic [N-1:0]      sum_q;
  logic              cout_q;
  logic              res_valid_q;
  logic              start_ready_q;
  logic              busy_q;

  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;

  // Chunk selector feeding the shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned c = 0; c < CHUNKS; c++) begin
      if (idx_q == c[IdxW-1:0]) begin
        add_a = a_q[c*WIDTH +: WIDTH];
        add_b = b_q[c*WIDTH +: WIDTH];
      end
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Subtraction is A + ~B + ~cin, so B and the carry are pre-inverted at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            a_q           <= op_a;
            b_q           <= op_b ^ {N{op_sub}};
            carry_q       <= op_cin ^ op_sub;
            idx_q         <= '0;
            state_q       <= StRun;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        StRun: begin
          for (int unsigned c = 0; c < CHUNKS; c++) begin
            if (idx_q == c[IdxW-1:0]) begin
              sum_q[c*WIDTH +: WIDTH] <= add_sum;
            end
          end
          carry_q <= add_cout;
          if (idx_q == LastIdx) begin
            cout_q      <= add_cout;
            idx_q       <= '0;
            state_q     <= StDone;
            res_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q       <= StIdle;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= StIdle;
          res_valid_q   <= 1'b0;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mp_add_ctrl;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned N      = WIDTH * CHUNKS;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

  int n_tests;
  int n_fail;

  mp_add_ctrl #(
    .WIDTH  (WIDTH),
    .CHUNKS (CHUNKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {cout, sum} from integer arithmetic on the full-width operands.
  function automatic logic [N:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin, input logic sub);
    longint x;
    logic [63:0] xv;
    if (!sub) begin
      x = longint'(a) + longint'(b) + longint'(cin);
      xv = 64'(x);
      return xv[N:0];
    end
    x = longint'(a) - longint'(b) - longint'(cin);
    xv = 64'(x);
    return {(x >= 0), xv[N-1:0]};
  endfunction

  task automatic issue_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub);
    logic [N:0] exp;
    int cyc;
    exp = ref_model(a, b, cin, sub);
    @(negedge clk);
    check_eq({tag, ".start_ready"}, 64'(start_ready), 64'(1));
    op_a        = a;
    op_b        = b;
    op_cin      = cin;
    op_sub      = sub;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands after the accept edge; the result must not care.
    start_valid = 1'b0;
    op_a        = N'($urandom);
    op_b        = N'($urandom);
    op_cin      = 1'($urandom);
    op_sub      = 1'($urandom);
    check_eq({tag, ".busy"}, 64'(busy), 64'(1));
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < int'(4 * CHUNKS + 8)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, ".latency"}, 64'(cyc), 64'(CHUNKS));
    check_eq({tag, ".sum"}, 64'(sum), 64'(exp[N-1:0]));
    check_eq({tag, ".cout"}, 64'(cout), 64'(exp[N]));
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check_eq({tag, ".idle_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, ".idle_ready"}, 64'(start_ready), 64'(1));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub, input int unsigned hold);
    logic [N-1:0] held;
    issue_op(tag, a, b, cin, sub);
    held = sum;
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".hold"}, 64'(sum), 64'(held));
    end
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_cin      = 1'b0;
    op_sub      = 1'b0;
    #12 rst = 1'b0;
    #1;
    check_eq("por.start_ready", 64'(start_ready), 64'(1));
    check_eq("por.res_valid", 64'(res_valid), 64'(0));

    // Plain add, then asynchronous reset while holding the result in DONE.
    issue_op("add", 24'h123456, 24'h654321, 1'b1, 1'b0);
    check_eq("add.sum_const", 64'(sum), 64'(24'h777778));
    check_eq("add.cout_const", 64'(cout), 64'(0));
    #3 rst = 1'b1;
    #1;
    check_eq("rst.sum", 64'(sum), 64'(0));
    check_eq("rst.cout", 64'(cout), 64'(0));
    check_eq("rst.res_valid", 64'(res_valid), 64'(0));
    check_eq("rst.busy", 64'(busy), 64'(0));
    check_eq("rst.start_ready", 64'(start_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    run_op("ripple", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 0);
    check_eq("ripple.sum_const", 64'(sum), 64'(24'h000000));
    check_eq("ripple.cout_const", 64'(cout), 64'(1));
    run_op("borrow", 24'h000005, 24'h000007, 1'b0, 1'b1, 1);
    check_eq("borrow.sum_const", 64'(sum), 64'(24'hFFFFFE));
    check_eq("borrow.cout_const", 64'(cout), 64'(0));
    run_op("noborrow", 24'h000007, 24'h000005, 1'b0, 1'b1, 0);
    check_eq("noborrow.sum_const", 64'(sum), 64'(24'h000002));
    check_eq("noborrow.cout_const", 64'(cout), 64'(1));

    // Backpressure: result held, new requests ignored while DONE.
    issue_op("bp", 24'h00003F, 24'h000000, 1'b1, 1'b0);
    check_eq("bp.sum_const", 64'(sum), 64'(24'h000040));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_valid = (i % 2 == 0);
      op_a        = N'($urandom);
      op_b        = N'($urandom);
      @(posedge clk);
      #1;
      check_eq("bp.sum_stable", 64'(sum), 64'(24'h000040));
      check_eq("bp.res_valid", 64'(res_valid), 64'(1));
      check_eq("bp.start_ready", 64'(start_ready), 64'(0));
    end
    @(negedge clk);
    start_valid = 1'b0;
    finish_op("bp");
    @(posedge clk);
    #1;
    check_eq("bp.not_accepted", 64'(busy), 64'(0));
    check_eq("bp.sum_after", 64'(sum), 64'(24'h000040));

    // Reset during RUN aborts the operation without a result.
    @(negedge clk);
    op_a        = 24'h00ABCD;
    op_b        = 24'h001111;
    op_cin      = 1'b0;
    op_sub      = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort.busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) seen++;
    end
    check_eq("abort.no_result", 64'(seen), 64'(0));
    run_op("after_abort", 24'h000001, 24'h000001, 1'b0, 1'b0, 0);
    check_eq("after_abort.sum_const", 64'(sum), 64'(24'h000002));

    for (int i = 0; i < 40; i++) begin
      run_op("rand", N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
